// File: rtl/trace_retire_merge_if.sv
// Commit, writeback and merged-record signals of the trace retire merge block.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface trace_retire_merge_if #(
    parameter int XLEN = 32
);
    logic            commit_valid;
    logic            commit_ready;
    logic [XLEN-1:0] commit_pc;
    logic [31:0]     commit_inst;
    logic            commit_wb;

    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            out_rdv;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_data;
    logic            err;

    modport master (
        output commit_valid, commit_pc, commit_inst, commit_wb,
        input  commit_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        input  out_valid, out_pc, out_inst, out_rdv, out_rd, out_data, err
    );

    modport slave (
        input  commit_valid, commit_pc, commit_inst, commit_wb,
        output commit_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        output out_valid, out_pc, out_inst, out_rdv, out_rd, out_data, err
    );
endinterface

// File: rtl/trace_retire_merge.sv
// Pairs in-order commits with their later in-order writebacks and emits one
// registered, program-ordered trace record per cycle.
module trace_retire_merge #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic clk,
    input  logic rst_n,
    trace_retire_merge_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        POP_NONE,
        POP_C,
        POP_CW,
        POP_W
    } pop_e;

    logic [XLEN-1:0] c_pc_mem   [DEPTH];
    logic [31:0]     c_inst_mem [DEPTH];
    logic            c_wb_mem   [DEPTH];
    logic [4:0]      w_rd_mem   [DEPTH];
    logic [XLEN-1:0] w_data_mem [DEPTH];

    logic [AW:0] c_wr_q, c_rd_q, w_wr_q, w_rd_q;
    logic        c_empty, c_full, w_empty, w_full;
    logic        c_push, w_push;
    pop_e        pop;

    logic [XLEN-1:0] c_head_pc;
    logic [31:0]     c_head_inst;
    logic            c_head_wb;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;

    assign c_empty = (c_wr_q == c_rd_q);
    assign w_empty = (w_wr_q == w_rd_q);
    assign c_full  = (c_wr_q[AW-1:0] == c_rd_q[AW-1:0]) && (c_wr_q[AW] != c_rd_q[AW]);
    assign w_full  = (w_wr_q[AW-1:0] == w_rd_q[AW-1:0]) && (w_wr_q[AW] != w_rd_q[AW]);

    // Ready depends on registered pointers only, so a pop never frees a slot in the same cycle.
    assign bus.commit_ready = !c_full;
    assign bus.wb_ready     = !w_full;
    assign c_push = bus.commit_valid && !c_full;
    assign w_push = bus.wb_valid && !w_full;

    assign c_head_pc   = c_pc_mem[c_rd_q[AW-1:0]];
    assign c_head_inst = c_inst_mem[c_rd_q[AW-1:0]];
    assign c_head_wb   = c_wb_mem[c_rd_q[AW-1:0]];
    assign w_head_rd   = w_rd_mem[w_rd_q[AW-1:0]];
    assign w_head_data = w_data_mem[w_rd_q[AW-1:0]];

    always_comb begin
        pop = POP_NONE;
        if (!c_empty) begin
            if (!c_head_wb)
                pop = POP_C;
            else if (!w_empty)
                pop = POP_CW;
        end else if (!w_empty) begin
            pop = POP_W;
        end
    end

    always_ff @(posedge clk) begin
        if (c_push) begin
            c_pc_mem[c_wr_q[AW-1:0]]   <= bus.commit_pc;
            c_inst_mem[c_wr_q[AW-1:0]] <= bus.commit_inst;
            c_wb_mem[c_wr_q[AW-1:0]]   <= bus.commit_wb;
        end
        if (w_push) begin
            w_rd_mem[w_wr_q[AW-1:0]]   <= bus.wb_rd;
            w_data_mem[w_wr_q[AW-1:0]] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_wr_q <= '0;
            c_rd_q <= '0;
            w_wr_q <= '0;
            w_rd_q <= '0;
        end else begin
            if (c_push)
                c_wr_q <= c_wr_q + 1'b1;
            if (w_push)
                w_wr_q <= w_wr_q + 1'b1;
            if (pop == POP_C || pop == POP_CW)
                c_rd_q <= c_rd_q + 1'b1;
            if (pop == POP_CW || pop == POP_W)
                w_rd_q <= w_rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_pc    <= '0;
            bus.out_inst  <= '0;
            bus.out_rdv   <= 1'b0;
            bus.out_rd    <= '0;
            bus.out_data  <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_rdv   <= 1'b0;
            case (pop)
                POP_C: begin
                    bus.out_valid <= 1'b1;
                    bus.out_pc    <= c_head_pc;
                    bus.out_inst  <= c_head_inst;
                end
                POP_CW: begin
                    bus.out_valid <= 1'b1;
                    bus.out_pc    <= c_head_pc;
                    bus.out_inst  <= c_head_inst;
                    bus.out_rdv   <= 1'b1;
                    bus.out_rd    <= w_head_rd;
                    bus.out_data  <= w_head_data;
                    if (c_head_inst[11:7] != w_head_rd)
                        bus.err <= 1'b1;
                end
                POP_W: begin
                    bus.out_rdv  <= 1'b1;
                    bus.out_rd   <= w_head_rd;
                    bus.out_data <= w_head_data;
                    bus.err      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_retire_merge.sv
// Directed bench for trace_retire_merge: vector table for single commit/writeback
// pairs plus hand-written sequences for stalls, back-pressure, reset and errors.
module tb_trace_retire_merge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    trace_retire_merge_if #(.XLEN(32)) bus ();

    trace_retire_merge #(.DEPTH(4), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
        int          wb_delay;
        logic        exp_rdv;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_commit(input logic [31:0] pc, input logic [31:0] inst, input logic wb);
        bus.commit_valid = 1'b1;
        bus.commit_pc    = pc;
        bus.commit_inst  = inst;
        bus.commit_wb    = wb;
        tick();
        bus.commit_valid = 1'b0;
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] pc, input logic rdv,
                           input logic [4:0] rd, input logic [31:0] data);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_pc"}, 64'(bus.out_pc), 64'(pc));
        chk({name, "_rdv"}, 64'(bus.out_rdv), 64'(rdv));
        if (rdv) begin
            chk({name, "_rd"}, 64'(bus.out_rd), 64'(rd));
            chk({name, "_data"}, 64'(bus.out_data), 64'(data));
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_rdv", 64'(bus.out_rdv), 64'd0);
        chk("rst_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_inst", 64'(bus.out_inst), 64'd0);
        chk("rst_rd", 64'(bus.out_rd), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_cready", 64'(bus.commit_ready), 64'd1);
        chk("rst_wready", 64'(bus.wb_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int lat;
        int idx;
        logic quiet;
        logic acc_c, acc_w;
        logic [31:0] exp_pcs[5];

        bus.commit_valid = 1'b0;
        bus.commit_pc    = '0;
        bus.commit_inst  = '0;
        bus.commit_wb    = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_data      = '0;

        vecs[0] = '{32'h100, 32'h00000013, 1'b0, 5'd0, 32'h0, 0, 1'b0, 1};
        vecs[1] = '{32'h104, 32'h00500093, 1'b1, 5'd1, 32'h5, 3, 1'b1, 4};
        vecs[2] = '{32'h108, 32'h00a00113, 1'b1, 5'd2, 32'ha, 1, 1'b1, 2};
        vecs[3] = '{32'h10c, 32'h00000073, 1'b0, 5'd0, 32'h0, 0, 1'b0, 1};
        vecs[4] = '{32'h110, 32'h002081b3, 1'b1, 5'd3, 32'hf, 2, 1'b1, 3};

        do_reset();

        // Single commit/writeback pairs with known latency.
        for (int v = 0; v < 5; v++) begin
            quiet = 1'b1;
            push_commit(vecs[v].pc, vecs[v].inst, vecs[v].wb);
            lat = 0;
            if (vecs[v].wb) begin
                for (int d = 1; d < vecs[v].wb_delay; d++) begin
                    tick();
                    if (bus.out_valid || bus.out_rdv) quiet = 1'b0;
                end
                push_wb(vecs[v].rd, vecs[v].data);
                if (bus.out_valid || bus.out_rdv) quiet = 1'b0;
                lat = vecs[v].wb_delay;
                chk($sformatf("v%0d_stall", v), 64'(quiet), 64'd1);
            end
            for (int w = 0; w < 20 && !bus.out_valid; w++) begin
                tick();
                lat++;
            end
            chk($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
            chk_out($sformatf("v%0d", v), vecs[v].pc, vecs[v].exp_rdv, vecs[v].rd, vecs[v].data);
            chk($sformatf("v%0d_inst", v), 64'(bus.out_inst), 64'(vecs[v].inst));
            tick();
            chk($sformatf("v%0d_single", v), 64'(bus.out_valid), 64'd0);
        end

        // Writeback of the head delayed: nothing emitted until it arrives, then A,B,C back to back.
        push_commit(32'h200, 32'h00500093, 1'b1);
        push_commit(32'h204, 32'h00000013, 1'b0);
        push_commit(32'h208, 32'h00000013, 1'b0);
        quiet = 1'b1;
        for (int d = 0; d < 4; d++) begin
            tick();
            if (bus.out_valid || bus.out_rdv) quiet = 1'b0;
        end
        push_wb(5'd1, 32'h55);
        if (bus.out_valid || bus.out_rdv) quiet = 1'b0;
        chk("skew_stall", 64'(quiet), 64'd1);
        tick();
        chk_out("skew_a", 32'h200, 1'b1, 5'd1, 32'h55);
        tick();
        chk_out("skew_b", 32'h204, 1'b0, 5'd0, 32'h0);
        tick();
        chk_out("skew_c", 32'h208, 1'b0, 5'd0, 32'h0);
        tick();
        chk("skew_end", 64'(bus.out_valid), 64'd0);

        // Fill the commit FIFO behind a stalled head, hold a fifth commit, then release.
        push_commit(32'h300, 32'h00500093, 1'b1);
        push_commit(32'h304, 32'h00000013, 1'b0);
        push_commit(32'h308, 32'h00000013, 1'b0);
        push_commit(32'h30c, 32'h00000013, 1'b0);
        chk("full_ready", 64'(bus.commit_ready), 64'd0);
        exp_pcs = '{32'h300, 32'h304, 32'h308, 32'h30c, 32'h310};
        bus.commit_valid = 1'b1;
        bus.commit_pc    = 32'h310;
        bus.commit_inst  = 32'h00000013;
        bus.commit_wb    = 1'b0;
        bus.wb_valid     = 1'b1;
        bus.wb_rd        = 5'd1;
        bus.wb_data      = 32'h77;
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            acc_c = bus.commit_valid && bus.commit_ready;
            acc_w = bus.wb_valid && bus.wb_ready;
            tick();
            if (acc_c) bus.commit_valid = 1'b0;
            if (acc_w) bus.wb_valid = 1'b0;
            if (c == 0) chk("full_held", 64'(bus.commit_ready), 64'd0);
            if (bus.out_valid) begin
                if (idx < 5) begin
                    chk($sformatf("full_pc%0d", idx), 64'(bus.out_pc), 64'(exp_pcs[idx]));
                    if (idx == 0) begin
                        chk("full_rdv", 64'(bus.out_rdv), 64'd1);
                        chk("full_data", 64'(bus.out_data), 64'h77);
                    end
                end else begin
                    chk("full_extra", 64'(bus.out_pc), 64'd0);
                end
                idx++;
            end
        end
        chk("full_count", 64'(idx), 64'd5);
        chk("full_err", 64'(bus.err), 64'd0);
        bus.commit_valid = 1'b0;
        bus.wb_valid     = 1'b0;

        // Reset with three entries queued; stale head would stall the fresh commit.
        push_commit(32'h600, 32'h00500093, 1'b1);
        push_commit(32'h604, 32'h00000013, 1'b0);
        push_commit(32'h608, 32'h00000013, 1'b0);
        do_reset();
        chk("post_rst_quiet", 64'(bus.out_valid), 64'd0);
        push_commit(32'h400, 32'h00000013, 1'b0);
        tick();
        chk_out("post_rst", 32'h400, 1'b0, 5'd0, 32'h0);

        // Merged record with mismatched rd: still emitted with the writeback rd, err raised.
        push_commit(32'h500, 32'h00500093, 1'b1);
        push_wb(5'd5, 32'h9);
        tick();
        chk_out("rd_mis", 32'h500, 1'b1, 5'd5, 32'h9);
        chk("rd_mis_err", 64'(bus.err), 64'd1);
        do_reset();

        // Writeback with no commit queued.
        push_wb(5'd3, 32'hdead);
        tick();
        chk("orphan_valid", 64'(bus.out_valid), 64'd0);
        chk("orphan_rdv", 64'(bus.out_rdv), 64'd1);
        chk("orphan_rd", 64'(bus.out_rd), 64'd3);
        chk("orphan_data", 64'(bus.out_data), 64'hdead);
        chk("orphan_err", 64'(bus.err), 64'd1);
        repeat (3) tick();
        chk("orphan_sticky", 64'(bus.err), 64'd1);
        chk("orphan_rdv_clr", 64'(bus.out_rdv), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
